// File: rtl/bicubic_result_streamer.sv
// Purpose: streams the TWxTH upscaler result from ResultSRAM in raster order, with LINE_END/FRAME_END markers.
// Latency: START to first PIX_VALID is 3 cycles; one pixel per cycle sustained while PIX_READY stays high.
// Backpressure: PIX_READY low holds the FIFO head; reads stop once buffered plus in-flight reach FIFO_DEPTH.

module bicubic_result_streamer #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [5:0]        TW,
  input  logic [5:0]        TH,
  output logic              SRAM_CEN,
  output logic [ADDR_W-1:0] SRAM_A,
  input  logic [DATA_W-1:0] SRAM_Q,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              LINE_END,
  output logic              FRAME_END,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  // FIFO sizing: pointer width, occupancy width, and a one-bit-wider sum width
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t            state_q, state_d;

  // Frame geometry and raster position
  logic [5:0]        tw_q, th_q;
  logic [5:0]        col_q, row_q;
  logic [11:0]       total_q;
  logic [11:0]       rd_ptr_q;
  logic [11:0]       out_ptr_q;

  // A read issued last cycle returns its data on SRAM_Q this cycle
  logic              inflight_q;
  logic [ADDR_W-1:0] sram_a_q;

  // Prefetch FIFO storage; the array is rounded up to a power of two so
  // every pointer value indexes a real entry
  logic [DATA_W-1:0] fifo_mem_q [2**PW];
  logic [PW-1:0]     fifo_wr_q, fifo_rd_q;
  logic [CW-1:0]     occ_q;

  logic [11:0]       start_total;
  logic              start_acc;
  logic [SW-1:0]     pending;
  logic              room;
  logic              issue;
  logic              push;
  logic              pop;
  logic              last_pop;
  logic              col_last;
  logic              row_last;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // 6x6-bit product fits 12 bits (63*63 = 3969)
  assign start_total = {6'd0, TW} * {6'd0, TH};
  assign start_acc   = (state_q == S_IDLE) && START;

  // Issue gate uses registered occupancy and in-flight state only
  assign pending  = {1'b0, occ_q} + {{CW{1'b0}}, inflight_q};
  assign room     = pending < SW'(FIFO_DEPTH);

  assign push     = inflight_q;
  assign pop      = PIX_VALID && PIX_READY;
  assign last_pop = pop && (out_ptr_q == total_q - 12'd1);
  assign col_last = (col_q == tw_q - 6'd1);
  assign row_last = (row_q == th_q - 6'd1);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: empty frames skip straight to the done pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = (start_total == 12'd0) ? S_FLUSH : S_STREAM;
        end
      end
      S_STREAM: begin
        if (last_pop) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: read issue while streaming, BUSY, and the FRAME_DONE pulse.
  always_comb begin
    issue      = 1'b0;
    BUSY       = 1'b0;
    FRAME_DONE = 1'b0;
    case (state_q)
      S_STREAM: begin
        BUSY  = 1'b1;
        issue = (rd_ptr_q < total_q) && room;
      end
      S_FLUSH: FRAME_DONE = 1'b1;
      default: ;
    endcase
  end

  // SRAM_A shows the live read pointer on a request, otherwise the last requested address
  assign SRAM_CEN = ~issue;
  assign SRAM_A   = issue ? ADDR_W'(rd_ptr_q) : sram_a_q;

  // Read pointer, frame geometry and raster position; reset drops any in-flight read.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tw_q       <= '0;
      th_q       <= '0;
      total_q    <= '0;
      rd_ptr_q   <= '0;
      out_ptr_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      sram_a_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + 12'd1;
        sram_a_q <= ADDR_W'(rd_ptr_q);
      end
      if (start_acc) begin
        tw_q      <= TW;
        th_q      <= TH;
        total_q   <= start_total;
        rd_ptr_q  <= '0;
        out_ptr_q <= '0;
        col_q     <= '0;
        row_q     <= '0;
      end else if (pop) begin
        out_ptr_q <= out_ptr_q + 12'd1;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + 6'd1;
        end else begin
          col_q <= col_q + 6'd1;
        end
      end
    end
  end

  // Prefetch FIFO: push/pop in the same cycle keeps occupancy unchanged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < (2**PW); i++) begin
        fifo_mem_q[i] <= '0;
      end
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
      occ_q     <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[fifo_wr_q] <= SRAM_Q;
        fifo_wr_q             <= ptr_inc(fifo_wr_q);
      end
      if (pop) begin
        fifo_rd_q <= ptr_inc(fifo_rd_q);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign PIX_VALID = (occ_q != '0);
  assign PIX_DATA  = fifo_mem_q[fifo_rd_q];
  assign LINE_END  = col_last && PIX_VALID;
  assign FRAME_END = col_last && row_last && PIX_VALID;

endmodule
